// File: rtl/s_muldiv_seq_pkg.sv
// Shared types and constants for the sequential multiply/divide unit.
// Contents:
//   muldiv_op_type    operation select encoding (MUL = 0, DIV = 1)
//   muldiv_state_type control FSM states
//   AN/AV/AH/AZ/AC    bit positions of the flags inside the 5-bit flag vector
package s_muldiv_seq_pkg;

  typedef enum logic {
    SC_MD_MUL = 1'b0,
    SC_MD_DIV = 1'b1
  } muldiv_op_type;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIN  = 2'd3
  } muldiv_state_type;

  localparam int FLG_W = 5;
  localparam int AN    = 4;
  localparam int AV    = 3;
  localparam int AH    = 2;
  localparam int AZ    = 1;
  localparam int AC    = 0;

endpackage

// File: rtl/s_muldiv_seq_div.sv
// s_div_step: one combinational iteration of the SPC700 restoring-style
// divide. The remainder/quotient register is rotated left by one bit and
// then conditionally reduced by the pre-shifted divisor. Running W+1 of these
// back to back reproduces the SPC700 DIV results, overflow cases included.
// Ports:
//   r       in   2W+1  working register before this iteration
//   d       in   2W+1  divisor shifted left by W+1
//   r_next  out  2W+1  working register after this iteration
module s_div_step #(
  parameter int W = 8
) (
  input  logic [2*W:0] r,
  input  logic [2*W:0] d,
  output logic [2*W:0] r_next
);

  logic [2*W:0] rot;
  logic [2*W:0] marked;

  // The rotate feeds the top bit back into bit 0. If that bit is already set
  // and the compare also succeeds, the toggle clears it again, which is what
  // gives the characteristic overflow results.
  always_comb begin
    rot    = {r[2*W-1:0], r[2*W]};
    marked = rot;
    if (rot >= d) begin
      marked[0] = ~rot[0];
    end
    r_next = marked[0] ? (marked - d) : marked;
  end

endmodule

// File: rtl/s_muldiv_seq.sv
// s_muldiv_seq: sequential MUL YA / DIV YA,X unit for the SPC700 core.
// The CPU pulses start while the unit is idle, then waits for done.
// MUL is shift-add (W cycles) or single-cycle when MUL_FAST=1; DIV runs
// W+1 iterations of s_div_step.
// Ports:
//   clk      in   1     system clock
//   reset    in   1     asynchronous active-high reset
//   start    in   1     request, honoured only in IDLE
//   op       in   1     0 = MUL, 1 = DIV
//   ya_in    in   2W    {Y,A}: MUL factors / DIV dividend
//   x_in     in   W     divisor
//   busy     out  1     operation in flight (MUL/DIV/FIN)
//   done     out  1     single-cycle completion pulse
//   ya_out   out  2W    MUL product or {remainder, quotient}
//   flgs     out  5     N/V/H/Z/C values at AN/AV/AH/AZ/AC
//   flgs_we  out  5     which flags the CPU should write back
import s_muldiv_seq_pkg::*;

module s_muldiv_seq #(
  parameter int W        = 8,
  parameter bit MUL_FAST = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [2*W-1:0]   ya_in,
  input  logic [W-1:0]     x_in,
  output logic             busy,
  output logic             done,
  output logic [2*W-1:0]   ya_out,
  output logic [FLG_W-1:0] flgs,
  output logic [FLG_W-1:0] flgs_we
);

  localparam int CNT_W = $clog2(W + 2);

  muldiv_state_type state, state_n;

  logic [CNT_W-1:0] cnt;
  logic [W-1:0]     x_reg;
  logic [3:0]       y_lo;
  logic [2*W:0]     r;
  logic [2*W:0]     r_next;
  logic [2*W:0]     div_d;
  logic [2*W-1:0]   acc;
  logic [2*W-1:0]   acc_next;
  logic [2*W-1:0]   mcand;
  logic [W-1:0]     mplier;
  logic [2*W-1:0]   prod_fast;
  logic [2*W-1:0]   mul_res;
  logic [2*W-1:0]   div_res;
  logic [FLG_W-1:0] mul_flg;
  logic [FLG_W-1:0] div_flg;
  logic [FLG_W-1:0] mul_we;
  logic [FLG_W-1:0] div_we;
  logic             mul_last;
  logic             div_last;
  logic             accept;

  assign accept   = (state == IDLE) && start;
  assign mul_last = MUL_FAST || (cnt == CNT_W'(W - 1));
  assign div_last = (cnt == CNT_W'(W));
  assign div_d    = {x_reg, {(W + 1){1'b0}}};

  s_div_step #(.W(W)) u_div_step (
    .r      (r),
    .d      (div_d),
    .r_next (r_next)
  );

  // Arithmetic feeding the result registers. The final value is taken from
  // the combinational next-step value so that ya_out is already valid in FIN.
  always_comb begin
    acc_next  = mplier[0] ? (acc + mcand) : acc;
    prod_fast = {{W{1'b0}}, mplier} * {{W{1'b0}}, mcand[W-1:0]};
    mul_res   = MUL_FAST ? prod_fast : acc_next;
    div_res   = {r_next[2*W:W+1], r_next[W-1:0]};

    mul_flg     = '0;
    mul_flg[AN] = mul_res[2*W-1];
    mul_flg[AZ] = (mul_res[2*W-1:W] == '0);
    mul_flg[AC] = 1'b0;
    mul_we      = '0;
    mul_we[AN]  = 1'b1;
    mul_we[AZ]  = 1'b1;
    mul_we[AC]  = 1'b0;

    div_flg     = '0;
    div_flg[AN] = r_next[W-1];
    div_flg[AV] = r_next[W];
    div_flg[AH] = (y_lo >= x_reg[3:0]);
    div_flg[AZ] = (r_next[W-1:0] == '0);
    div_flg[AC] = 1'b0;
    div_we      = '0;
    div_we[AN]  = 1'b1;
    div_we[AV]  = 1'b1;
    div_we[AH]  = 1'b1;
    div_we[AZ]  = 1'b1;
    div_we[AC]  = 1'b0;
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // FSM next state. FIN always returns to IDLE, so a start seen in FIN is
  // dropped rather than queued.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = (muldiv_op_type'(op) == SC_MD_DIV) ? DIV : MUL;
        end
      end
      MUL: begin
        if (mul_last) begin
          state_n = FIN;
        end
      end
      DIV: begin
        if (div_last) begin
          state_n = FIN;
        end
      end
      FIN: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy = (state != IDLE);
    done = (state == FIN);
  end

  // Operand latching, iteration registers and result/flag registers.
  // Results stay put until the next operation completes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      x_reg   <= '0;
      y_lo    <= '0;
      r       <= '0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      ya_out  <= '0;
      flgs    <= '0;
      flgs_we <= '0;
    end else begin
      if (accept) begin
        cnt    <= '0;
        x_reg  <= x_in;
        y_lo   <= ya_in[W+3:W];
        r      <= {1'b0, ya_in};
        acc    <= '0;
        mcand  <= {{W{1'b0}}, ya_in[W-1:0]};
        mplier <= ya_in[2*W-1:W];
      end else if (state == MUL) begin
        cnt    <= cnt + 1'b1;
        acc    <= acc_next;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        if (mul_last) begin
          ya_out  <= mul_res;
          flgs    <= mul_flg;
          flgs_we <= mul_we;
        end
      end else if (state == DIV) begin
        cnt <= cnt + 1'b1;
        r   <= r_next;
        if (div_last) begin
          ya_out  <= div_res;
          flgs    <= div_flg;
          flgs_we <= div_we;
        end
      end
    end
  end

endmodule
